minitb_ahb_slave: RTL

MINITB_AHB_SLAVE -- requirements
Module: minitb_ahb_slave

---
 rtl/minitb_ahb_slave.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/minitb_ahb_slave.sv
// minitb_ahb_slave
//   Memory-backed AHB-lite-subset responder for the minitb master's
//   IDLE/NONSEQ single-transfer protocol. It accepts an address phase while
//   hready is high. It optionally inserts wait states. It completes the
//   transfer in a one-cycle data phase.
//
//   Configuration macro: MINITB_AHB_SLAVE_WAIT_EN
//     defined   -> each transfer gets waitStates hready-low cycles (WAIT state)
//     undefined -> WAIT state and counter are not built, every transfer is
//                  zero-wait and waitStates is ignored
//
//   Ports
//     hclk        in   clock, all state changes on the rising edge
//     rst         in   synchronous active-high reset
//     htrans[1:0] in   2'b10 NONSEQ, every other encoding is IDLE
//     haddr       in   word address into the internal memory
//     hwrite      in   1 = write, 0 = read
//     hwdata      in   write data, sampled in the data phase
//     hready      out  0 while wait states are inserted, otherwise 1
//     hrdata      out  read data during a read data phase, else 0
//     xfer_count  out  completed-transfer counter, wraps at 16 bits
module minitb_ahb_slave #(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 32,
  parameter int waitStates = 2
) (
  input  logic                 hclk,
  input  logic                 rst,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  output logic                 hready,
  output logic [dataWidth-1:0] hrdata,
  output logic [15:0]          xfer_count
);

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // The counter is 4 bits wide, so reject wait counts it cannot hold.
  if (waitStates < 0 || waitStates > 15) begin : g_bad_wait_states
    $error("minitb_ahb_slave: waitStates must be in 0..15");
  end

`ifdef MINITB_AHB_SLAVE_WAIT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd2
  } state_t;
`endif

  state_t                 state_reg, state_next;
  logic [addrWidth-1:0]   addr_q, addr_next;
  logic                   write_q, write_next;
  logic [15:0]            count_reg, count_next;
  logic                   accept;
  logic                   complete;
`ifdef MINITB_AHB_SLAVE_WAIT_EN
  logic [3:0]             wait_cnt_reg, wait_cnt_next;
`endif

  logic [dataWidth-1:0]   mem [0:(2**addrWidth)-1];

  assign xfer_count = count_reg;

  always_comb begin
    hready     = 1'b1;
`ifdef MINITB_AHB_SLAVE_WAIT_EN
    if (state_reg == ST_WAIT) hready = 1'b0;
    wait_cnt_next = wait_cnt_reg;
`endif
    complete   = (state_reg == ST_DATA);
    accept     = (htrans == HTRANS_NONSEQ) && hready;
    state_next = state_reg;
    addr_next  = addr_q;
    write_next = write_q;
    count_next = complete ? count_reg + 16'd1 : count_reg;

    // The read port is combinational so that data is valid in the same
    // cycle as the data phase. A write that completed on the previous edge
    // is therefore already visible.
    hrdata = '0;
    if (complete && !write_q) hrdata = mem[addr_q];

    case (state_reg)
`ifdef MINITB_AHB_SLAVE_WAIT_EN
      ST_WAIT: begin
        wait_cnt_next = wait_cnt_reg - 4'd1;
        if (wait_cnt_reg == 4'd1) state_next = ST_DATA;
      end
`endif
      ST_DATA: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Acceptance is only possible while hready is high, which is IDLE or
    // DATA. In DATA this overrides the return to IDLE, so transfers can run
    // back-to-back.
    if (accept) begin
      addr_next  = haddr;
      write_next = hwrite;
`ifdef MINITB_AHB_SLAVE_WAIT_EN
      if (waitStates > 0) begin
        state_next    = ST_WAIT;
        wait_cnt_next = 4'(waitStates);
      end else begin
        state_next = ST_DATA;
      end
`else
      state_next = ST_DATA;
`endif
    end
  end

  always_ff @(posedge hclk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      count_reg    <= '0;
`ifdef MINITB_AHB_SLAVE_WAIT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      addr_q       <= addr_next;
      write_q      <= write_next;
      count_reg    <= count_next;
`ifdef MINITB_AHB_SLAVE_WAIT_EN
      wait_cnt_reg <= wait_cnt_next;
`endif
    end
  end

  // Memory has no reset. A reset edge suppresses the pending write so that
  // an interrupted transfer leaves memory untouched.
  always_ff @(posedge hclk) begin
    if (!rst && complete && write_q) mem[addr_q] <= hwdata;
  end

endmodule
